reg_bank8x16: RTL and testbench



---
 rtl/reg_bank8x16.sv | 94 +++++++++
 tb/tb_reg_bank8x16.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank8x16.sv
// Eight-entry register bank feeding an 8:1 mux: single write port, scan counter
// driving the mux select, and a one-entry-per-cycle clear sweep.
//
// state | meaning
// IDLE  | writes accepted, clear request sampled
// CLEAR | sweeping entry[idx] <= CLEAR_VAL, idx 0..7; load and clear ignored
module reg_bank8x16 #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       address,
    input  logic             load,
    input  logic             clear,
    input  logic             scan_en,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic [2:0]       sel,
    output logic             busy,
    output logic             scan_wrap
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state, state_next;
    logic [2:0]       idx;
    logic [WIDTH-1:0] mem [8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear) state_next = CLEAR;
            CLEAR:   if (idx == 3'd7) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy tracks the state the FSM is entering, so it rises on the entry edge
    // and falls on the edge that writes entry 7
    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= 1'b0;
        else       busy <= (state_next == CLEAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                idx <= 3'd0;
        else if (state == CLEAR)  idx <= idx + 3'd1;
        else                      idx <= 3'd0;
    end

    // reset value is zero regardless of CLEAR_VAL
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (state == CLEAR) begin
            mem[idx] <= CLEAR_VAL;
        end else if (load && !clear) begin
            mem[address] <= in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel       <= 3'd0;
            scan_wrap <= 1'b0;
        end else begin
            scan_wrap <= scan_en && (sel == 3'd7);
            if (scan_en) sel <= sel + 3'd1;
        end
    end

    assign r0 = mem[0];
    assign r1 = mem[1];
    assign r2 = mem[2];
    assign r3 = mem[3];
    assign r4 = mem[4];
    assign r5 = mem[5];
    assign r6 = mem[6];
    assign r7 = mem[7];

endmodule

// File: tb/tb_reg_bank8x16.sv
// Scoreboard bench for reg_bank8x16: two instances (CLEAR_VAL 0 and 16'hFFFF)
// share stimulus; a behavioural model queues expected outputs per edge.
module tb_reg_bank8x16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_d;
    logic [2:0]  address;
    logic        load, clear, scan_en;

    logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [15:0] b0, b1, b2, b3, b4, b5, b6, b7;
    logic [2:0]  sel_a, sel_b;
    logic        busy_a, busy_b, wrap_a, wrap_b;

    logic [7:0][15:0] obs_a, obs_b;
    assign obs_a = {a7, a6, a5, a4, a3, a2, a1, a0};
    assign obs_b = {b7, b6, b5, b4, b3, b2, b1, b0};

    always #5 clk = ~clk;

    reg_bank8x16 dut_a (
        .clk(clk), .reset(reset), .in(in_d), .address(address), .load(load),
        .clear(clear), .scan_en(scan_en),
        .r0(a0), .r1(a1), .r2(a2), .r3(a3), .r4(a4), .r5(a5), .r6(a6), .r7(a7),
        .sel(sel_a), .busy(busy_a), .scan_wrap(wrap_a)
    );

    reg_bank8x16 #(.WIDTH(16), .CLEAR_VAL(16'hFFFF)) dut_b (
        .clk(clk), .reset(reset), .in(in_d), .address(address), .load(load),
        .clear(clear), .scan_en(scan_en),
        .r0(b0), .r1(b1), .r2(b2), .r3(b3), .r4(b4), .r5(b5), .r6(b6), .r7(b7),
        .sel(sel_b), .busy(busy_b), .scan_wrap(wrap_b)
    );

    typedef struct packed {
        logic [7:0][15:0] ra;
        logic [7:0][15:0] rb;
        logic [2:0]       sel;
        logic             busy;
        logic             wrap;
    } exp_t;

    exp_t q_exp[$];

    logic [7:0][15:0] m_a, m_b;
    logic [2:0]       m_sel, m_idx;
    logic             m_busy, m_wrap, m_clr;

    int n_vec = 0;
    int n_err = 0;
    int n;

    task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0;
        m_sel = 3'd0; m_idx = 3'd0;
        m_busy = 1'b0; m_wrap = 1'b0; m_clr = 1'b0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.ra = m_a; e.rb = m_b; e.sel = m_sel; e.busy = m_busy; e.wrap = m_wrap;
        q_exp.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (q_exp.size() == 0) begin
            chk_val("queue_empty", 16'd0, 16'd1);
        end else begin
            e = q_exp.pop_front();
            for (int k = 0; k < 8; k++) begin
                chk_val($sformatf("a.r%0d", k), obs_a[k], e.ra[k]);
                chk_val($sformatf("b.r%0d", k), obs_b[k], e.rb[k]);
            end
            chk_val("a.sel", 16'(sel_a), 16'(e.sel));
            chk_val("b.sel", 16'(sel_b), 16'(e.sel));
            chk_val("a.busy", 16'(busy_a), 16'(e.busy));
            chk_val("b.busy", 16'(busy_b), 16'(e.busy));
            chk_val("a.wrap", 16'(wrap_a), 16'(e.wrap));
            chk_val("b.wrap", 16'(wrap_b), 16'(e.wrap));
            chk_val("a.mux", obs_a[e.sel], e.ra[e.sel]);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, compare after the edge.
    task automatic cyc(input logic ld, input logic [2:0] ad, input logic [15:0] d,
                       input logic clr, input logic sen);
        load = ld; address = ad; in_d = d; clear = clr; scan_en = sen;
        if (m_clr) begin
            m_a[m_idx] = 16'h0000;
            m_b[m_idx] = 16'hFFFF;
            if (m_idx == 3'd7) begin
                m_clr = 1'b0;
                m_busy = 1'b0;
            end
            m_idx = m_idx + 3'd1;
        end else if (clr) begin
            m_clr = 1'b1; m_idx = 3'd0; m_busy = 1'b1;
        end else if (ld) begin
            m_a[ad] = d; m_b[ad] = d;
        end
        if (sen) begin
            m_wrap = (m_sel == 3'd7);
            m_sel = m_sel + 3'd1;
        end else begin
            m_wrap = 1'b0;
        end
        push_exp();
        @(posedge clk);
        #1;
        pop_cmp();
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        push_exp();
        pop_cmp();
        #2;
        reset = 1'b0;
    endtask

    task automatic fill();
        for (int k = 0; k < 8; k++) cyc(1'b1, 3'(k), 16'(16'h1111 * (k + 1)), 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; load = 1'b1; in_d = 16'hFFFF; address = 3'd0;
        clear = 1'b0; scan_en = 1'b0;
        model_reset();

        // 1: reset dominates a pending load, then a single write
        #1;
        push_exp(); pop_cmp();
        @(posedge clk); #1;
        push_exp(); pop_cmp();
        #2 reset = 1'b0;
        cyc(1'b1, 3'b101, 16'b0110100110000111, 1'b0, 1'b0);
        chk_val("t1.r5", obs_a[5], 16'h6987);
        chk_val("t1.r4", obs_a[4], 16'h0000);

        // 2: fill and scan a full lap
        fill();
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
            chk_val("t2.sel", 16'(sel_a), 16'((k + 1) % 8));
            chk_val("t2.wrap", 16'(wrap_a), 16'(k == 7));
            if (k == 2) chk_val("t2.mux3", obs_a[sel_a], 16'h4444);
        end

        // 3: sweep; load during sweep dropped
        n = 1;
        cyc(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        chk_val("t3.busy_entry", 16'(busy_a), 16'd1);
        cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        n++;
        chk_val("t3.r0_first", obs_a[0], 16'h0000);
        chk_val("t3.r1_held", obs_a[1], 16'h2222);
        while (busy_a && n < 20) begin
            cyc(1'b1, 3'd0, 16'hABCD, 1'b0, 1'b0);
            n++;
        end
        chk_val("t3.busy_edges", 16'(n), 16'd9);
        chk_val("t3.r7_last", obs_a[7], 16'h0000);
        chk_val("t3.r0_noload", obs_a[0], 16'h0000);

        // 4: clear beats load; mid-sweep clear ignored; back-to-back restart
        fill();
        n = 1;
        cyc(1'b1, 3'd2, 16'h1234, 1'b1, 1'b0);
        chk_val("t4.busy_start", 16'(busy_a), 16'd1);
        chk_val("t4.r2_noload", obs_a[2], 16'h3333);
        while (busy_a && n < 20) begin
            cyc(1'b0, 3'd0, 16'd0, (n == 4), 1'b0);
            n++;
        end
        chk_val("t4.busy_edges", 16'(n), 16'd9);
        chk_val("t4.r2_end", obs_a[2], 16'h0000);
        fill();
        n = 1;
        cyc(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        while (busy_a && n < 20) begin
            cyc(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
            n++;
        end
        chk_val("t4.b2b_edges", 16'(n), 16'd9);
        cyc(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        chk_val("t4.b2b_restart", 16'(busy_a), 16'd1);
        n = 1;
        while (busy_a && n < 20) begin
            cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
            n++;
        end
        chk_val("t4.restart_edges", 16'(n), 16'd9);

        // 5: reset mid-sweep
        fill();
        cyc(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        chk_val("t5.r3_swept", obs_a[3], 16'h0000);
        chk_val("t5.r4_pending", obs_a[4], 16'h5555);
        async_reset();
        cyc(1'b1, 3'd6, 16'h00FF, 1'b0, 1'b0);
        chk_val("t5.r6_write", obs_a[6], 16'h00FF);
        chk_val("t5.busy_idle", 16'(busy_a), 16'd0);
        cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

        // 6: scan hold, sweep to CLEAR_VAL while scanning
        async_reset();
        cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
        chk_val("t6.sel_en1", 16'(sel_b), 16'd1);
        cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        chk_val("t6.sel_hold", 16'(sel_b), 16'd1);
        cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
        chk_val("t6.sel_en2", 16'(sel_b), 16'd2);
        fill();
        n = 1;
        cyc(1'b0, 3'd0, 16'd0, 1'b1, 1'b1);
        while (busy_b && n < 20) begin
            cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
            n++;
        end
        chk_val("t6.busy_edges", 16'(n), 16'd9);
        for (int k = 0; k < 8; k++) begin
            chk_val($sformatf("t6.b.r%0d", k), obs_b[k], 16'hFFFF);
            chk_val($sformatf("t6.a.r%0d", k), obs_a[k], 16'h0000);
        end
        chk_val("t6.sel_after", 16'(sel_b), 16'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
